// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing A - B - Bin,
// one bit per clock, LSB first, with a registered borrow. Operands come in on
// a valid/ready handshake and the result goes out on a valid/ready handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;

    logic             d_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor on the current LSBs and the partial result after this bit.
    always_comb begin
        // NOTE: every signal here is assigned on every pass, so no latch is inferred.
        d_bit       = a_sh[0] ^ b_sh[0] ^ borrow;
        borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
        res_next    = {d_bit, res_sh[WIDTH-1:1]};
    end

    // Ready is decoded straight from state; no input reaches it combinationally.
    assign in_ready = (state == IDLE);

    // Control FSM and serial datapath; all outputs except in_ready are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            borrow    <= 1'b0;
            count     <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        res_sh <= '0;
                        borrow <= Bin;
                        count  <= '0;
                        a_msb  <= A[WIDTH-1];
                        b_msb  <= B[WIDTH-1];
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    borrow <= borrow_next;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        Diff      <= res_next;
                        Bout      <= borrow_next;
                        // Signed overflow: operand signs differ and the result sign
                        // disagrees with the minuend sign.
                        Ovf       <= (a_msb != b_msb) && (d_bit != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive-with-random-backpressure bench
// for serial_subtractor at WIDTH=4, checked against a signed/unsigned integer model.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Diff     (Diff),
        .Bout     (Bout),
        .Ovf      (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [5:0] model(input int a, input int b, input int bin);
        int u;
        int sa;
        int sb;
        int s;
        logic [3:0] d;
        logic bo;
        logic ov;
        u  = a - b - bin;
        d  = 4'(u + 32);
        bo = (u < 0);
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        s  = sa - sb - bin;
        ov = (s < -8) || (s > 7);
        return {ov, bo, d};
    endfunction

    // Present operands on a falling edge and let the next rising edge accept them.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bin);
        @(negedge clk);
        in_valid = 1'b1;
        A = a;
        B = b;
        Bin = bin;
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        A = 4'($urandom);
        B = 4'($urandom);
        Bin = 1'($urandom);
        check("run_not_ready", 32'(in_ready), 32'd0);
    endtask

    // Wait for the result, check latency and value, stall, then complete the handshake.
    task automatic collect(input logic [3:0] a, input logic [3:0] b, input logic bin,
                           input int stall, input bit hold_new);
        int lat;
        logic [5:0] exp;
        exp = model(int'(a), int'(b), int'(bin));
        lat = 0;
        out_ready = 1'b0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
            check("busy_not_ready", 32'(in_ready), 32'd0);
            if (lat > 20) begin
                check("result_timeout", 32'(lat), 32'(WIDTH));
                return;
            end
        end
        check("latency", 32'(lat), 32'(WIDTH));
        check("diff", 32'(Diff), 32'(exp[3:0]));
        check("bout", 32'(Bout), 32'(exp[4]));
        check("ovf", 32'(Ovf), 32'(exp[5]));
        check("done_not_ready", 32'(in_ready), 32'd0);
        if (hold_new) begin
            in_valid = 1'b1;
            A = 4'd9;
            B = 4'd2;
            Bin = 1'b0;
        end
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_diff", 32'(Diff), 32'(exp[3:0]));
            check("stall_bout", 32'(Bout), 32'(exp[4]));
            check("stall_ovf", 32'(Ovf), 32'(exp[5]));
            check("stall_not_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_valid_low", 32'(out_valid), 32'd0);
        check("hs_idle_ready", 32'(in_ready), 32'd1);
        check("hs_diff_kept", 32'(Diff), 32'(exp[3:0]));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(Diff), 32'd0);
        check("rst_bout", 32'(Bout), 32'd0);
        check("rst_ovf", 32'(Ovf), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Directed cases from the arithmetic rules.
        issue(4'd7, 4'd3, 1'b0);  collect(4'd7, 4'd3, 1'b0, 0, 1'b0);
        issue(4'd3, 4'd5, 1'b1);  collect(4'd3, 4'd5, 1'b1, 1, 1'b0);
        issue(4'd8, 4'd1, 1'b0);  collect(4'd8, 4'd1, 1'b0, 0, 1'b0);
        issue(4'd7, 4'hF, 1'b0);  collect(4'd7, 4'hF, 1'b0, 0, 1'b0);

        // Backpressure with new operands waiting; they are taken only after the handshake.
        issue(4'd7, 4'd3, 1'b0);
        collect(4'd7, 4'd3, 1'b0, 5, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accepted", 32'(in_ready), 32'd0);
        collect(4'd9, 4'd2, 1'b0, 0, 1'b0);

        // Reset two cycles into RUN aborts the operation.
        issue(4'd5, 4'd6, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_diff", 32'(Diff), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check("abort_no_pulse", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        issue(4'd0, 4'd0, 1'b1);  collect(4'd0, 4'd0, 1'b1, 0, 1'b0);

        // Exhaustive sweep with random downstream stalls.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue(4'(a), 4'(b), 1'(c));
                    collect(4'(a), 4'(b), 1'(c), int'($urandom_range(0, 2)), 1'b0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor that computes A − B − Bin one bit per clock, LSB first, using full-subtractor logic and a registered borrow. It is the inverse-operation companion to the combinational ripple-carry adder chain, and it trades latency for a single-bit datapath. Operands are accepted on a valid/ready input handshake, and the result is presented on a valid/ready output handshake. It sits in the arithmetic library alongside the full-adder and ripple-adder blocks.

## Interface
Parameters:
- WIDTH, default 4: operand and result width, WIDTH ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands A, B and Bin are valid.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  Diff, Bout and Ovf hold a completed result.
- out_ready  input  1  downstream accepts the result.
- Diff  output  WIDTH  difference, (A − B − Bin) mod 2^WIDTH.
- Bout  output  1  borrow-out; 1 when the unsigned result is negative.
- Ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset:
  - state = IDLE, out_valid = 0, Diff = 0, Bout = 0, Ovf = 0.
  - All shift registers, the borrow register and the bit counter are cleared.
  - in_ready reads 1 because the state is IDLE.
- IDLE:
  - On in_valid && in_ready, latch A and B into shift registers, borrow ← Bin, count ← 0, and store A[WIDTH−1] and B[WIDTH−1].
  - Then go to RUN.
- RUN, each cycle:
  - d = a0 ^ b0 ^ borrow.
  - borrow ← (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - d is shifted into the MSB of the result shift register.
  - The A and B shift registers shift right by one.
  - count increments.
  - When count == WIDTH−1, the final bit is processed and the FSM goes to DONE.
  - On that same edge: Diff ← completed result, Bout ← final borrow, Ovf ← (A_msb != B_msb) && (Diff_msb != A_msb), and out_valid ← 1.
- DONE:
  - Diff, Bout and Ovf are held stable while out_valid = 1.
  - On out_valid && out_ready, out_valid ← 0 and the FSM goes to IDLE.
  - Diff, Bout and Ovf keep the last result until the next completion.
- in_ready = 0 in RUN and DONE. in_valid is ignored there; no queuing.
- Arithmetic identity: A − B − Bin = Diff − Bout·2^WIDTH, with A and B taken as unsigned.
- Asynchronous reset in any state aborts the operation immediately. No out_valid pulse follows, and the outputs return to their reset values.
- Illegal state encodings recover to IDLE.

## Timing
- Acceptance edge at cycle k: the first bit is processed on edge k+1.
- out_valid is asserted after edge k+WIDTH, i.e. WIDTH cycles after acceptance.
- Minimum issue interval with out_ready held high is WIDTH+2 cycles: 1 IDLE + WIDTH RUN + 1 DONE.
- out_ready held low stalls in DONE indefinitely with all outputs stable.
- All outputs are registered except in_ready, which is decoded from state.
- There is no combinational path from any input to any output.

## Test plan
- Reset:
  - Assert rst_n = 0 mid-cycle → out_valid = 0, Diff = 0, Bout = 0, Ovf = 0, in_ready = 1 immediately.
  - Release → the block accepts on the next in_valid.
- WIDTH=4, A = 7, B = 3, Bin = 0 → Diff = 4, Bout = 0, Ovf = 0.
  - out_valid rises exactly 4 cycles after the acceptance edge.
  - in_ready = 0 throughout RUN and DONE.
- A = 3, B = 5, Bin = 1 → Diff = 0xD, Bout = 1, Ovf = 0.
- Overflow cases:
  - A = 8, B = 1, Bin = 0 → Diff = 7, Bout = 0, Ovf = 1.
  - A = 7, B = 0xF, Bin = 0 → Diff = 8, Bout = 1, Ovf = 1.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with new operands → out_valid, Diff, Bout and Ovf stay stable and no operands are accepted.
  - Raise out_ready → one-cycle handshake, then IDLE, then the next operands are accepted.
- Reset mid-operation:
  - Assert rst_n low 2 cycles into RUN → out_valid never pulses and Diff = 0.
  - After release, A = 0, B = 0, Bin = 1 → Diff = 0xF, Bout = 1, Ovf = 0.
- Exhaustive sweep for WIDTH=4: all A, B and Bin combinations with random out_ready → every result matches the arithmetic identity and the Ovf rule.
